// File: rtl/dcache_ctrl_assoc_pkg.sv
// rtl/dcache_ctrl_assoc_pkg.sv - shared types and width helpers for the associative dcache controller
package lc3b_types;

    typedef enum logic [2:0] {
        IDLE,
        WRITEBACK,
        READIN,
        TAGLOAD,
        NOALLOC,
        ERROR
    } dcache_state_t;

    // Index width for an n-entry selector; never narrower than one bit.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/dcache_ctrl_assoc_if.sv
// rtl/dcache_ctrl_assoc_if.sv - CPU, pmem and array-control signals of the dcache controller
interface dcache_ctrl_assoc_if
    import lc3b_types::*;
#(
    parameter int unsigned WAYS        = 2,
    parameter int unsigned BURST_BEATS = 4
);
    localparam int unsigned WW = idx_width(WAYS);
    localparam int unsigned BW = idx_width(BURST_BEATS);

    logic            mem_read;
    logic            mem_write;
    logic [WAYS-1:0] hit_vec;
    logic [WAYS-1:0] valid_vec;
    logic [WAYS-1:0] dirty_vec;
    logic [WW-1:0]   lru_way;
    logic            pmem_resp;
    logic            pmem_read;
    logic            pmem_write;
    logic [BW-1:0]   pmem_beat;
    logic            pmem_addr_sel;
    logic [WW-1:0]   way_sel;
    logic            data_we;
    logic            fill_we;
    logic            tag_load;
    logic            dirty_set;
    logic            lru_update;
    logic            mem_resp;
    logic            err;

    modport master (
        input  mem_read, mem_write, hit_vec, valid_vec, dirty_vec, lru_way, pmem_resp,
        output pmem_read, pmem_write, pmem_beat, pmem_addr_sel, way_sel, data_we,
               fill_we, tag_load, dirty_set, lru_update, mem_resp, err
    );

    modport slave (
        output mem_read, mem_write, hit_vec, valid_vec, dirty_vec, lru_way, pmem_resp,
        input  pmem_read, pmem_write, pmem_beat, pmem_addr_sel, way_sel, data_we,
               fill_we, tag_load, dirty_set, lru_update, mem_resp, err
    );

endinterface

// File: rtl/dcache_ctrl_assoc_victim_sel.sv
// rtl/dcache_ctrl_assoc_victim_sel.sv - hit index, multi-hit detect and replacement victim choice
module dcache_victim_sel
    import lc3b_types::*;
#(
    parameter int unsigned WAYS = 2,
    parameter int unsigned WW   = idx_width(WAYS)
) (
    input  logic [WAYS-1:0] valid_vec_i,
    input  logic [WAYS-1:0] hit_vec_i,
    input  logic [WW-1:0]   lru_way_i,
    output logic [WW-1:0]   victim_o,
    output logic [WW-1:0]   hit_idx_o,
    output logic            multi_hit_o
);
    int unsigned n_hits;

    // Walk from the top so the lowest-index invalid way wins.
    always_comb begin
        victim_o  = lru_way_i;
        hit_idx_o = '0;
        n_hits    = 0;
        for (int i = WAYS - 1; i >= 0; i--) begin
            if (!valid_vec_i[i]) victim_o = WW'(i);
            if (hit_vec_i[i]) begin
                hit_idx_o = WW'(i);
                n_hits    = n_hits + 1;
            end
        end
        multi_hit_o = (n_hits > 1);
    end

endmodule

// File: rtl/dcache_ctrl_assoc.sv
// rtl/dcache_ctrl_assoc.sv - write-back set-associative L1 dcache control FSM with burst line transfers
module dcache_ctrl_assoc
    import lc3b_types::*;
#(
    parameter int unsigned WAYS           = 2,
    parameter int unsigned BURST_BEATS    = 4,
    parameter bit          WRITE_ALLOCATE = 1'b1
) (
    input  logic           clk,
    input  logic           rst_n,
    dcache_ctrl_assoc_if.master bus
);
    localparam int unsigned   WW        = idx_width(WAYS);
    localparam int unsigned   BW        = idx_width(BURST_BEATS);
    localparam logic [BW-1:0] LAST_BEAT = BW'(BURST_BEATS - 1);

    dcache_state_t state_q, state_d;
    logic [BW-1:0] cnt_q, cnt_d;
    logic [WW-1:0] victim_q, victim_d;
    logic [WW-1:0] victim_idx, hit_idx;
    logic          multi_hit, req, last_beat;

    dcache_victim_sel #(.WAYS(WAYS), .WW(WW)) u_victim_sel (
        .valid_vec_i (bus.valid_vec),
        .hit_vec_i   (bus.hit_vec),
        .lru_way_i   (bus.lru_way),
        .victim_o    (victim_idx),
        .hit_idx_o   (hit_idx),
        .multi_hit_o (multi_hit)
    );

    assign req       = bus.mem_read | bus.mem_write;
    assign last_beat = (cnt_q == LAST_BEAT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            victim_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            victim_q <= victim_d;
        end
    end

    always_comb begin
        state_d           = state_q;
        cnt_d             = cnt_q;
        victim_d          = victim_q;
        bus.pmem_read     = 1'b0;
        bus.pmem_write    = 1'b0;
        bus.pmem_beat     = '0;
        bus.pmem_addr_sel = 1'b0;
        bus.way_sel       = victim_q;
        bus.data_we       = 1'b0;
        bus.fill_we       = 1'b0;
        bus.tag_load      = 1'b0;
        bus.dirty_set     = 1'b0;
        bus.lru_update    = 1'b0;
        bus.mem_resp      = 1'b0;
        bus.err           = (state_q == ERROR);

        case (state_q)
            IDLE: begin
                bus.way_sel = hit_idx;
                if (req) begin
                    if (multi_hit) begin
                        state_d = ERROR;
                    end else if (|bus.hit_vec) begin
                        bus.mem_resp   = 1'b1;
                        bus.lru_update = 1'b1;
                        bus.data_we    = bus.mem_write;
                        bus.dirty_set  = bus.mem_write;
                    end else if (bus.mem_write && !WRITE_ALLOCATE) begin
                        state_d = NOALLOC;
                    end else begin
                        victim_d = victim_idx;
                        state_d  = (bus.valid_vec[victim_idx] && bus.dirty_vec[victim_idx])
                                   ? WRITEBACK : READIN;
                    end
                end
            end
            WRITEBACK: begin
                bus.pmem_write    = 1'b1;
                bus.pmem_addr_sel = 1'b1;
                bus.pmem_beat     = cnt_q;
                if (bus.pmem_resp) begin
                    cnt_d = last_beat ? '0 : cnt_q + BW'(1);
                    if (last_beat) state_d = READIN;
                end
            end
            READIN: begin
                bus.pmem_read = 1'b1;
                bus.pmem_beat = cnt_q;
                bus.fill_we   = bus.pmem_resp;
                if (bus.pmem_resp) begin
                    cnt_d = last_beat ? '0 : cnt_q + BW'(1);
                    if (last_beat) state_d = TAGLOAD;
                end
            end
            TAGLOAD: begin
                bus.tag_load = 1'b1;
                state_d      = IDLE;
            end
            NOALLOC: begin
                bus.pmem_write = 1'b1;
                if (bus.pmem_resp) begin
                    bus.mem_resp = 1'b1;
                    state_d      = IDLE;
                end
            end
            ERROR: ;
            default: state_d = IDLE;
        endcase

        // Outputs are forced quiet for the whole time reset is held.
        if (!rst_n) begin
            bus.pmem_read     = 1'b0;
            bus.pmem_write    = 1'b0;
            bus.pmem_beat     = '0;
            bus.pmem_addr_sel = 1'b0;
            bus.way_sel       = '0;
            bus.data_we       = 1'b0;
            bus.fill_we       = 1'b0;
            bus.tag_load      = 1'b0;
            bus.dirty_set     = 1'b0;
            bus.lru_update    = 1'b0;
            bus.mem_resp      = 1'b0;
            bus.err           = 1'b0;
        end
    end

endmodule
